// File: rtl/timer_controller.sv
// Countdown timer controller: a prescaler emits one-cycle enables every TICK_DIV cycles
// while running, and a down-counter of whole ticks drives the display, the tick and done
// strobes and the expiry alarm. Everything runs on the single system clock.
module timer_controller #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   output logic [CNT_W-1:0] remaining,
   output logic             running,
   output logic             tick,
   output logic             done,
   output logic             expired
);

   // Prescaler width: enough bits to hold 0..TICK_DIV-1.
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE = PW'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   // A divider of 1 would make every RUN cycle a tick edge and leave no room to pause.
   if (TICK_DIV < 2) begin : g_bad_div
      $error("timer_controller: TICK_DIV must be at least 2");
   end

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRun     = 2'd1,
      StPause   = 2'd2,
      StExpired = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [CNT_W-1:0] remaining_d;
   logic             tick_d;
   logic             done_d;
   logic             running_d;
   logic             expired_d;
   logic             tick_event;

   // A tick falls on this edge when the prescaler has reached its last count while running.
   assign tick_event = (state_q == StRun) && (presc_q == PRESC_MAX);

   // State register: FSM state, prescaler, and every output flop.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         remaining <= '0;
         running   <= 1'b0;
         tick      <= 1'b0;
         done      <= 1'b0;
         expired   <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         remaining <= remaining_d;
         running   <= running_d;
         tick      <= tick_d;
         done      <= done_d;
         expired   <= expired_d;
      end
   end

   // Next-state logic: clear beats load, which beats the tick, which beats start/pause.
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      remaining_d = remaining;
      tick_d      = 1'b0;
      done_d      = 1'b0;

      if (clear) begin
         state_d     = StIdle;
         presc_d     = '0;
         remaining_d = '0;
      end else if (load) begin
         // Any tick due on this edge is dropped along with the old count.
         state_d     = StIdle;
         presc_d     = '0;
         remaining_d = load_value;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Never enter RUN with nothing to count, so remaining cannot wrap.
               if (start && (remaining != CNT_ZERO)) begin
                  state_d = StRun;
                  presc_d = '0;
               end
            end

            StRun: begin
               if (tick_event) begin
                  presc_d     = '0;
                  remaining_d = remaining - CNT_ONE;
                  tick_d      = 1'b1;
                  if (remaining == CNT_ONE) begin
                     done_d  = 1'b1;
                     state_d = StExpired;
                  end else if (pause) begin
                     state_d = StPause;
                  end
               end else begin
                  presc_d = presc_q + PRESC_ONE;
                  if (pause) begin
                     state_d = StPause;
                  end
               end
            end

            StPause: begin
               // Resume keeps the saved prescaler phase.
               if (start) begin
                  state_d = StRun;
               end
            end

            StExpired: begin
               // Only load or clear leaves this state.
               state_d = StExpired;
            end

            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   // Output logic: level outputs follow the state the edge is moving into.
   always_comb begin
      running_d = (state_d == StRun);
      expired_d = (state_d == StExpired);
   end

endmodule
